// File: rtl/fill_write_arbiter_pkg.sv
// Shared types for the fill/write arbiter: AXI word widths, packed {addr,data}
// word layout, source IDs and FSM states.
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 64
`endif

package fill_write_arbiter_pkg;

    localparam int AXI_ADDR_WIDTH = `AXI_ADDR_WIDTH;
    localparam int AXI_DATA_WIDTH = `AXI_DATA_WIDTH;

    // Word layout shared with the read-miss handler and ROB: address in the MSBs.
    typedef struct packed {
        logic [AXI_ADDR_WIDTH-1:0] addr;
        logic [AXI_DATA_WIDTH-1:0] data;
    } axi_word_t;

    typedef enum logic {
        SRC_FILL = 1'b0,
        SRC_WR   = 1'b1
    } src_id_e;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_ISSUE = 1'b1
    } state_e;

    function automatic int cnt_width(input int max_out);
        return $clog2(max_out + 1);
    endfunction

endpackage

// File: rtl/fill_write_arbiter_if.sv
// Bundle of the two source handshakes plus the AXI-style AW/W/B channels.
// master = the arbiter side, slave = the surrounding sources and memory controller.
interface fill_write_arbiter_if
    import fill_write_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH  = AXI_ADDR_WIDTH,
    parameter int DATA_WIDTH  = AXI_DATA_WIDTH,
    parameter int WDATA_WIDTH = ADDR_WIDTH + DATA_WIDTH
);
    logic                   fill_valid_i;
    logic                   fill_ready_o;
    logic [WDATA_WIDTH-1:0] fill_wdata_i;
    logic                   wr_valid_i;
    logic                   wr_ready_o;
    logic [WDATA_WIDTH-1:0] wr_wdata_i;
    logic                   aw_valid_o;
    logic                   aw_ready_i;
    logic [ADDR_WIDTH-1:0]  aw_addr_o;
    logic                   w_valid_o;
    logic                   w_ready_i;
    logic [DATA_WIDTH-1:0]  w_data_o;
    logic                   b_valid_i;
    logic                   b_ready_o;
    logic                   busy_o;

    modport master (
        input  fill_valid_i, fill_wdata_i, wr_valid_i, wr_wdata_i,
        input  aw_ready_i, w_ready_i, b_valid_i,
        output fill_ready_o, wr_ready_o, aw_valid_o, aw_addr_o,
        output w_valid_o, w_data_o, b_ready_o, busy_o
    );

    modport slave (
        output fill_valid_i, fill_wdata_i, wr_valid_i, wr_wdata_i,
        output aw_ready_i, w_ready_i, b_valid_i,
        input  fill_ready_o, wr_ready_o, aw_valid_o, aw_addr_o,
        input  w_valid_o, w_data_o, b_ready_o, busy_o
    );
endinterface

// File: rtl/fill_write_arbiter_rr_arbiter2.sv
// Two-requester round-robin grant; on a tie the source that did not win last
// time is granted. Grants are combinational, rr_last is registered.
module rr_arbiter2
    import fill_write_arbiter_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic allow_i,
    input  logic req_fill_i,
    input  logic req_wr_i,
    output logic gnt_fill_o,
    output logic gnt_wr_o
);
    src_id_e rr_last_q;
    src_id_e rr_last_d;

    always_comb begin
        gnt_fill_o = 1'b0;
        gnt_wr_o   = 1'b0;
        rr_last_d  = rr_last_q;
        if (allow_i) begin
            if (req_fill_i && req_wr_i) begin
                if (rr_last_q == SRC_WR) gnt_fill_o = 1'b1;
                else                     gnt_wr_o   = 1'b1;
            end else if (req_fill_i) begin
                gnt_fill_o = 1'b1;
            end else if (req_wr_i) begin
                gnt_wr_o = 1'b1;
            end
        end
        if (gnt_fill_o) rr_last_d = SRC_FILL;
        if (gnt_wr_o)   rr_last_d = SRC_WR;
    end

    // Reset to SRC_WR so the fill stream wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rr_last_q <= SRC_WR;
        else        rr_last_q <= rr_last_d;
    end
endmodule

// File: rtl/fill_write_arbiter.sv
// Arbitrates read-miss fill words against write-path words and issues each
// winner as one AW+W write, bounding writes still awaiting their B response.
module fill_write_arbiter
    import fill_write_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH      = AXI_ADDR_WIDTH,
    parameter int DATA_WIDTH      = AXI_DATA_WIDTH,
    parameter int WDATA_WIDTH     = ADDR_WIDTH + DATA_WIDTH,
    parameter int MAX_OUTSTANDING = 4
)(
    input  logic                 clk,
    input  logic                 rst_n,
    fill_write_arbiter_if.master bus
);
    localparam int              CNT_W   = cnt_width(MAX_OUTSTANDING);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

    state_e                 state_q, state_d;
    logic                   aw_valid_q, aw_valid_d;
    logic                   w_valid_q, w_valid_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [DATA_WIDTH-1:0]  data_q, data_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    logic                   grant_allow;
    logic                   gnt_fill;
    logic                   gnt_wr;
    logic [WDATA_WIDTH-1:0] sel_word;
    logic                   issue_done;
    logic                   b_take;

    // rst_n gates the grant so no ready can leak out while reset is held.
    assign grant_allow = rst_n && (state_q == S_IDLE) && (cnt_q < CNT_MAX);

    rr_arbiter2 u_rr (
        .clk        (clk),
        .rst_n      (rst_n),
        .allow_i    (grant_allow),
        .req_fill_i (bus.fill_valid_i),
        .req_wr_i   (bus.wr_valid_i),
        .gnt_fill_o (gnt_fill),
        .gnt_wr_o   (gnt_wr)
    );

    assign sel_word = gnt_fill ? bus.fill_wdata_i : bus.wr_wdata_i;

    // A cleared valid flag means that channel's handshake already finished.
    assign issue_done = (state_q == S_ISSUE)
                     && (!aw_valid_q || bus.aw_ready_i)
                     && (!w_valid_q  || bus.w_ready_i);

    // A B with nothing outstanding is a protocol error; ignore it instead of wrapping.
    assign b_take = bus.b_valid_i && (cnt_q != '0);

    always_comb begin
        state_d    = state_q;
        aw_valid_d = aw_valid_q;
        w_valid_d  = w_valid_q;
        addr_d     = addr_q;
        data_d     = data_q;
        cnt_d      = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (gnt_fill || gnt_wr) begin
                    addr_d     = sel_word[WDATA_WIDTH-1 -: ADDR_WIDTH];
                    data_d     = sel_word[DATA_WIDTH-1:0];
                    aw_valid_d = 1'b1;
                    w_valid_d  = 1'b1;
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (aw_valid_q && bus.aw_ready_i) aw_valid_d = 1'b0;
                if (w_valid_q && bus.w_ready_i)   w_valid_d  = 1'b0;
                if (issue_done)                   state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        case ({issue_done, b_take})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            aw_valid_q <= 1'b0;
            w_valid_q  <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            aw_valid_q <= aw_valid_d;
            w_valid_q  <= w_valid_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.fill_ready_o = gnt_fill;
    assign bus.wr_ready_o   = gnt_wr;
    assign bus.aw_valid_o   = aw_valid_q;
    assign bus.aw_addr_o    = addr_q;
    assign bus.w_valid_o    = w_valid_q;
    assign bus.w_data_o     = data_q;
    assign bus.b_ready_o    = 1'b1;
    assign bus.busy_o       = (state_q != S_IDLE) || (cnt_q != '0);
endmodule

// File: tb/tb_fill_write_arbiter.sv
// Directed bench for fill_write_arbiter: reset, single issue, tie fairness,
// split AW/W handshake, outstanding limit, simultaneous B, async reset.
module tb_fill_write_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    int   tests_run = 0;
    int   tests_failed = 0;
    int   tb_out;

    always #5 clk = ~clk;

    fill_write_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(64)) bus ();

    fill_write_arbiter #(
        .ADDR_WIDTH(32), .DATA_WIDTH(64), .MAX_OUTSTANDING(4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Independent count of completed writes, used to guard against B underflow.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tb_out <= 0;
        end else begin
            assert (!(bus.b_valid_i && tb_out == 0))
                else $error("FAIL b_underflow: b_valid with tb outstanding %0d, need >0", tb_out);
            tb_out <= tb_out + ((bus.w_valid_o && bus.w_ready_i) ? 1 : 0) - (bus.b_valid_i ? 1 : 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.fill_valid_i = 1'b0;
        bus.fill_wdata_i = '0;
        bus.wr_valid_i   = 1'b0;
        bus.wr_wdata_i   = '0;
        bus.aw_ready_i   = 1'b0;
        bus.w_ready_i    = 1'b0;
        bus.b_valid_i    = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic issue_fill(input logic [31:0] a);
        bit got;
        got = 1'b0;
        bus.fill_valid_i = 1'b1;
        bus.fill_wdata_i = {a, 64'(a)};
        for (int k = 0; k < 10 && !got; k++) begin
            #1;
            got = bus.fill_ready_o;
            tick();
        end
        bus.fill_valid_i = 1'b0;
        for (int k = 0; k < 10 && (bus.aw_valid_o || bus.w_valid_o); k++) tick();
        tests_run++;
        if (!got) begin tests_failed++; $display("FAIL issue_fill_grant: addr %0h never granted, want grant", a); end
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        bus.fill_valid_i = 1'b1;
        bus.wr_valid_i   = 1'b1;
        tick();
        tests_run++; if (bus.fill_ready_o !== 1'b0) begin tests_failed++; $display("FAIL reset_fill_ready: got %b want 0", bus.fill_ready_o); end
        tests_run++; if (bus.wr_ready_o !== 1'b0) begin tests_failed++; $display("FAIL reset_wr_ready: got %b want 0", bus.wr_ready_o); end
        tests_run++; if (bus.aw_valid_o !== 1'b0) begin tests_failed++; $display("FAIL reset_aw_valid: got %b want 0", bus.aw_valid_o); end
        tests_run++; if (bus.w_valid_o !== 1'b0) begin tests_failed++; $display("FAIL reset_w_valid: got %b want 0", bus.w_valid_o); end
        tests_run++; if (bus.busy_o !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", bus.busy_o); end
        tests_run++; if (bus.aw_addr_o !== 32'h0) begin tests_failed++; $display("FAIL reset_aw_addr: got %h want 0", bus.aw_addr_o); end
        tests_run++; if (bus.w_data_o !== 64'h0) begin tests_failed++; $display("FAIL reset_w_data: got %h want 0", bus.w_data_o); end
        tests_run++; if (bus.b_ready_o !== 1'b1) begin tests_failed++; $display("FAIL reset_b_ready: got %b want 1", bus.b_ready_o); end
        $display("[TB] test_reset done");
    endtask

    task automatic test_single_fill();
        do_reset();
        bus.aw_ready_i = 1'b1;
        bus.w_ready_i  = 1'b1;
        bus.fill_valid_i = 1'b1;
        bus.fill_wdata_i = {32'h0000_1000, 64'hDEAD_BEEF_0000_0001};
        #1;
        tests_run++; if (bus.fill_ready_o !== 1'b1) begin tests_failed++; $display("FAIL single_grant_ready: got %b want 1", bus.fill_ready_o); end
        tests_run++; if (bus.aw_valid_o !== 1'b0) begin tests_failed++; $display("FAIL single_aw_early: got %b want 0", bus.aw_valid_o); end
        tick();
        bus.fill_valid_i = 1'b0;
        #1;
        tests_run++; if (bus.fill_ready_o !== 1'b0) begin tests_failed++; $display("FAIL single_ready_pulse: got %b want 0", bus.fill_ready_o); end
        tests_run++; if (bus.aw_valid_o !== 1'b1 || bus.w_valid_o !== 1'b1) begin tests_failed++; $display("FAIL single_issue_valid: got aw=%b w=%b want 1/1", bus.aw_valid_o, bus.w_valid_o); end
        tests_run++; if (bus.aw_addr_o !== 32'h0000_1000) begin tests_failed++; $display("FAIL single_aw_addr: got %h want 00001000", bus.aw_addr_o); end
        tests_run++; if (bus.w_data_o !== 64'hDEAD_BEEF_0000_0001) begin tests_failed++; $display("FAIL single_w_data: got %h want deadbeef00000001", bus.w_data_o); end
        tick();
        tests_run++; if (bus.aw_valid_o !== 1'b0 || bus.w_valid_o !== 1'b0) begin tests_failed++; $display("FAIL single_valid_drop: got aw=%b w=%b want 0/0", bus.aw_valid_o, bus.w_valid_o); end
        tick();
        tick();
        bus.b_valid_i = 1'b1;
        #1;
        tests_run++; if (bus.busy_o !== 1'b1) begin tests_failed++; $display("FAIL single_busy_before_b: got %b want 1", bus.busy_o); end
        tick();
        bus.b_valid_i = 1'b0;
        tests_run++; if (bus.busy_o !== 1'b0) begin tests_failed++; $display("FAIL single_busy_after_b: got %b want 0", bus.busy_o); end
        $display("[TB] test_single_fill done");
    endtask

    task automatic test_tie_fairness();
        logic [31:0] seen [8];
        logic [31:0] exp_addr;
        int n, fi, wi, pend;
        bit fgo, wgo, awgo, bgo;
        do_reset();
        bus.aw_ready_i = 1'b1;
        bus.w_ready_i  = 1'b1;
        n = 0; fi = 0; wi = 0; pend = 0;
        for (int k = 0; k < 8; k++) seen[k] = '0;
        for (int cyc = 0; cyc < 60 && n < 8; cyc++) begin
            bus.fill_valid_i = (fi < 4);
            bus.fill_wdata_i = {32'h100 + 32'(fi), 64'(fi)};
            bus.wr_valid_i   = (wi < 4);
            bus.wr_wdata_i   = {32'h200 + 32'(wi), 64'(wi)};
            bus.b_valid_i    = (pend > 0);
            #1;
            fgo  = bus.fill_ready_o;
            wgo  = bus.wr_ready_o;
            awgo = bus.aw_valid_o && bus.aw_ready_i;
            bgo  = bus.b_valid_i;
            if (awgo) begin seen[n] = bus.aw_addr_o; n++; end
            tick();
            if (fgo)  fi++;
            if (wgo)  wi++;
            if (awgo) pend++;
            if (bgo)  pend--;
        end
        clear_inputs();
        tests_run++; if (n !== 8) begin tests_failed++; $display("FAIL fair_aw_count: got %0d want 8", n); end
        for (int k = 0; k < 8; k++) begin
            exp_addr = (k % 2 == 0) ? 32'h100 + 32'(k / 2) : 32'h200 + 32'(k / 2);
            tests_run++; if (seen[k] !== exp_addr) begin tests_failed++; $display("FAIL fair_aw_order[%0d]: got %h want %h", k, seen[k], exp_addr); end
        end
        $display("[TB] test_tie_fairness done");
    endtask

    task automatic test_split_handshake();
        do_reset();
        bus.aw_ready_i = 1'b1;
        bus.w_ready_i  = 1'b0;
        bus.fill_valid_i = 1'b1;
        bus.fill_wdata_i = {32'h3000, 64'h5};
        #1;
        tests_run++; if (bus.fill_ready_o !== 1'b1) begin tests_failed++; $display("FAIL split_grant: got %b want 1", bus.fill_ready_o); end
        tick();
        bus.fill_valid_i = 1'b0;
        bus.wr_valid_i   = 1'b1;
        bus.wr_wdata_i   = {32'h4000, 64'h6};
        for (int k = 0; k < 6; k++) begin
            bus.w_ready_i = (k == 5);
            #1;
            tests_run++; if (bus.w_valid_o !== 1'b1) begin tests_failed++; $display("FAIL split_w_valid[%0d]: got %b want 1", k, bus.w_valid_o); end
            tests_run++; if (bus.aw_valid_o !== (k == 0)) begin tests_failed++; $display("FAIL split_aw_valid[%0d]: got %b want %b", k, bus.aw_valid_o, (k == 0)); end
            tests_run++; if (bus.wr_ready_o !== 1'b0) begin tests_failed++; $display("FAIL split_no_grant[%0d]: got %b want 0", k, bus.wr_ready_o); end
            tick();
        end
        bus.w_ready_i = 1'b0;
        #1;
        tests_run++; if (bus.w_valid_o !== 1'b0) begin tests_failed++; $display("FAIL split_w_drop: got %b want 0", bus.w_valid_o); end
        tests_run++; if (bus.wr_ready_o !== 1'b1) begin tests_failed++; $display("FAIL split_next_grant: got %b want 1", bus.wr_ready_o); end
        bus.wr_valid_i = 1'b0;
        $display("[TB] test_split_handshake done");
    endtask

    task automatic test_outstanding_limit();
        int n, aws;
        bit fgo;
        do_reset();
        bus.aw_ready_i = 1'b1;
        bus.w_ready_i  = 1'b1;
        n = 0; aws = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            bus.fill_valid_i = (n < 6);
            bus.fill_wdata_i = {32'h500 + 32'(n), 64'(n)};
            #1;
            fgo = bus.fill_ready_o;
            if (bus.aw_valid_o && bus.aw_ready_i) aws++;
            tick();
            if (fgo) n++;
        end
        bus.fill_wdata_i = {32'h500 + 32'(n), 64'(n)};
        tests_run++; if (n !== 4) begin tests_failed++; $display("FAIL limit_grants: got %0d want 4", n); end
        tests_run++; if (aws !== 4) begin tests_failed++; $display("FAIL limit_aw_count: got %0d want 4", aws); end
        bus.b_valid_i = 1'b1;
        #1;
        tests_run++; if (bus.fill_ready_o !== 1'b0) begin tests_failed++; $display("FAIL limit_b_not_comb: got %b want 0", bus.fill_ready_o); end
        tick();
        bus.b_valid_i = 1'b0;
        #1;
        tests_run++; if (bus.fill_ready_o !== 1'b1) begin tests_failed++; $display("FAIL limit_grant_after_b: got %b want 1", bus.fill_ready_o); end
        tick();
        bus.fill_wdata_i = {32'h505, 64'h5};
        #1;
        tests_run++; if (bus.aw_valid_o !== 1'b1 || bus.aw_addr_o !== 32'h504) begin tests_failed++; $display("FAIL limit_fifth_aw: got valid=%b addr=%h want 1/504", bus.aw_valid_o, bus.aw_addr_o); end
        tick();
        #1;
        tests_run++; if (bus.fill_ready_o !== 1'b0) begin tests_failed++; $display("FAIL limit_full_again: got %b want 0", bus.fill_ready_o); end
        bus.fill_valid_i = 1'b0;
        $display("[TB] test_outstanding_limit done");
    endtask

    task automatic test_simultaneous_b();
        do_reset();
        bus.aw_ready_i = 1'b1;
        bus.w_ready_i  = 1'b1;
        issue_fill(32'h600);
        issue_fill(32'h601);
        issue_fill(32'h602);
        bus.fill_valid_i = 1'b1;
        bus.fill_wdata_i = {32'h603, 64'h3};
        #1;
        tests_run++; if (bus.fill_ready_o !== 1'b1) begin tests_failed++; $display("FAIL simb_fourth_grant: got %b want 1", bus.fill_ready_o); end
        tick();
        bus.fill_valid_i = 1'b0;
        bus.b_valid_i    = 1'b1;
        tick();
        bus.b_valid_i    = 1'b0;
        bus.fill_valid_i = 1'b1;
        bus.fill_wdata_i = {32'h604, 64'h4};
        #1;
        tests_run++; if (bus.fill_ready_o !== 1'b1) begin tests_failed++; $display("FAIL simb_grant_at_3: got %b want 1", bus.fill_ready_o); end
        tick();
        bus.fill_valid_i = 1'b0;
        tick();
        bus.fill_valid_i = 1'b1;
        bus.fill_wdata_i = {32'h605, 64'h5};
        #1;
        tests_run++; if (bus.fill_ready_o !== 1'b0) begin tests_failed++; $display("FAIL simb_full_at_4: got %b want 0", bus.fill_ready_o); end
        bus.fill_valid_i = 1'b0;
        $display("[TB] test_simultaneous_b done");
    endtask

    task automatic test_async_reset();
        do_reset();
        bus.aw_ready_i = 1'b1;
        bus.w_ready_i  = 1'b1;
        issue_fill(32'h6000);
        issue_fill(32'h6001);
        bus.aw_ready_i   = 1'b0;
        bus.w_ready_i    = 1'b0;
        bus.fill_valid_i = 1'b1;
        bus.fill_wdata_i = {32'h6002, 64'h2};
        tick();
        tests_run++; if (bus.aw_valid_o !== 1'b1) begin tests_failed++; $display("FAIL areset_in_issue: got %b want 1", bus.aw_valid_o); end
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++; if (bus.aw_valid_o !== 1'b0 || bus.w_valid_o !== 1'b0) begin tests_failed++; $display("FAIL areset_valids: got aw=%b w=%b want 0/0", bus.aw_valid_o, bus.w_valid_o); end
        tests_run++; if (bus.fill_ready_o !== 1'b0 || bus.wr_ready_o !== 1'b0) begin tests_failed++; $display("FAIL areset_readies: got fill=%b wr=%b want 0/0", bus.fill_ready_o, bus.wr_ready_o); end
        tests_run++; if (bus.busy_o !== 1'b0) begin tests_failed++; $display("FAIL areset_busy: got %b want 0", bus.busy_o); end
        tick();
        rst_n = 1'b1;
        bus.aw_ready_i   = 1'b1;
        bus.w_ready_i    = 1'b1;
        bus.fill_wdata_i = {32'h7000, 64'h7};
        #1;
        tests_run++; if (bus.fill_ready_o !== 1'b1) begin tests_failed++; $display("FAIL areset_regrant: got %b want 1", bus.fill_ready_o); end
        tick();
        bus.fill_valid_i = 1'b0;
        tests_run++; if (bus.aw_valid_o !== 1'b1 || bus.aw_addr_o !== 32'h7000) begin tests_failed++; $display("FAIL areset_aw: got valid=%b addr=%h want 1/7000", bus.aw_valid_o, bus.aw_addr_o); end
        tick();
        bus.b_valid_i = 1'b1;
        tick();
        bus.b_valid_i = 1'b0;
        tests_run++; if (bus.busy_o !== 1'b0) begin tests_failed++; $display("FAIL areset_count_cleared: got busy=%b want 0", bus.busy_o); end
        $display("[TB] test_async_reset done");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_fill();
        test_tie_fairness();
        test_split_handshake();
        test_outstanding_limit();
        test_simultaneous_b();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
